// File: rtl/parallel_to_serial.sv
// Serializes WIDTH-bit words LSB first through a shift register plus a one-word holding buffer.
// Optional macro PARALLEL_TO_SERIAL_PARITY_EN appends an even-parity beat to every word.
module parallel_to_serial #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             parallel_valid,
    input  logic [WIDTH-1:0] parallel_data,
    output logic             parallel_ready,
    output logic             serial_valid,
    output logic             serial_data,
    output logic             serial_last,
    input  logic             serial_ready,
    output logic [CNT_W-1:0] word_cnt
);

`ifdef PARALLEL_TO_SERIAL_PARITY_EN
    localparam int NBEATS = WIDTH + 1;
`else
    localparam int NBEATS = WIDTH;
`endif
    localparam int BCW = $clog2(NBEATS);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef PARALLEL_TO_SERIAL_PARITY_EN
    function automatic logic even_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    function automatic logic [NBEATS-1:0] frame(input logic [WIDTH-1:0] d);
        return {even_parity(d), d};
    endfunction
`else
    function automatic logic [NBEATS-1:0] frame(input logic [WIDTH-1:0] d);
        return d;
    endfunction
`endif

    state_t             state_r, state_s;
    logic [NBEATS-1:0]  shift_r, shift_s;
    logic [WIDTH-1:0]   buf_r, buf_s;
    logic               buf_full_r, buf_full_s;
    logic [BCW-1:0]     bit_cnt_r, bit_cnt_s;
    logic               last_r, last_s;
    logic               ready_r, ready_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               xfer_s, last_xfer_s, accept_s, load_in_s;

    // Next-state, routing and counter logic
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        bit_cnt_s   = bit_cnt_r;
        last_s      = last_r;
        xfer_s      = (state_r == SHIFT) && serial_ready;
        last_xfer_s = xfer_s && last_r;
        accept_s    = parallel_valid && ready_r;
        load_in_s   = accept_s && ((state_r == IDLE) || last_xfer_s);

        // B can only be full while S is busy, so a direct load never overtakes B
        if (load_in_s) begin
            shift_s   = frame(parallel_data);
            bit_cnt_s = '0;
            last_s    = 1'b0;
            state_s   = SHIFT;
        end else if (last_xfer_s && buf_full_r) begin
            shift_s   = frame(buf_r);
            bit_cnt_s = '0;
            last_s    = 1'b0;
            state_s   = SHIFT;
        end else if (last_xfer_s) begin
            shift_s   = '0;
            bit_cnt_s = '0;
            last_s    = 1'b0;
            state_s   = IDLE;
        end else if (xfer_s) begin
            shift_s   = shift_r >> 1;
            bit_cnt_s = bit_cnt_r + BCW'(1);
            last_s    = (bit_cnt_r == BCW'(NBEATS - 2));
        end else begin
            state_s   = state_r;
        end

        buf_full_s = (accept_s && !load_in_s) || (buf_full_r && !last_xfer_s);
        buf_s      = (accept_s && !load_in_s) ? parallel_data : buf_r;
        ready_s    = !buf_full_s;
        cnt_s      = last_xfer_s ? (cnt_r + CNT_W'(1)) : cnt_r;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            buf_r      <= '0;
            buf_full_r <= 1'b0;
            bit_cnt_r  <= '0;
            last_r     <= 1'b0;
            ready_r    <= 1'b1;
            cnt_r      <= '0;
        end else begin
            state_r    <= state_s;
            shift_r    <= shift_s;
            buf_r      <= buf_s;
            buf_full_r <= buf_full_s;
            bit_cnt_r  <= bit_cnt_s;
            last_r     <= last_s;
            ready_r    <= ready_s;
            cnt_r      <= cnt_s;
        end
    end

    assign parallel_ready = ready_r;
    assign serial_valid   = (state_r == SHIFT);
    assign serial_data    = shift_r[0];
    assign serial_last    = last_r;
    assign word_cnt       = cnt_r;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench for parallel_to_serial: queue-based word model compared every cycle,
// directed scenarios with literal expectations, and a randomized soak.
module tb_parallel_to_serial;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;
`ifdef PARALLEL_TO_SERIAL_PARITY_EN
    localparam int NB    = WIDTH + 1;
    localparam int BASE  = 1;
`else
    localparam int NB    = WIDTH;
    localparam int BASE  = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pv  = 1'b0;
    logic [WIDTH-1:0] pd  = '0;
    logic             sr  = 1'b0;
    logic             parallel_ready, serial_valid, serial_data, serial_last;
    logic [CNT_W-1:0] word_cnt;

    parallel_to_serial #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .parallel_valid(pv), .parallel_data(pd), .parallel_ready(parallel_ready),
        .serial_valid(serial_valid), .serial_data(serial_data), .serial_last(serial_last),
        .serial_ready(sr), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out, required event never came", name);
    endtask

    // Inputs and DUT outputs as seen by each rising edge
    logic rst_q = 1'b0, pv_q = 1'b0, sr_q = 1'b0, cap_sv = 1'b0, cap_sd = 1'b0, cap_sl = 1'b0;
    logic [WIDTH-1:0] pd_q = '0;
    always @(posedge clk) begin
        rst_q  <= rst;
        pv_q   <= pv;
        pd_q   <= pd;
        sr_q   <= sr;
        cap_sv <= serial_valid;
        cap_sd <= serial_data;
        cap_sl <= serial_last;
    end

    // Model: pending words in acceptance order, beat index of the head word
    logic [WIDTH-1:0] mq[$];
    int               m_idx = 0;
    logic [CNT_W-1:0] m_cnt = '0;

    // Collected output stream
    logic [WIDTH-1:0] words_out[$];
    int               lens_out[$];
    logic             last_bit[$];
    int               xfer_cyc[$];
    int               c_idx = 0;
    logic [WIDTH-1:0] c_cur = '0;
    int               cyc = 0;
    logic             saw_nr = 1'b0;

    function automatic logic exp_bit(input logic [WIDTH-1:0] w, input int k);
        if (k < WIDTH) return w[k];
        return ^w;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst || !rst_q) begin
                mq.delete();
                m_idx = 0;
                m_cnt = '0;
                c_idx = 0;
                c_cur = '0;
            end else begin
                logic acc;
                acc = pv_q && (mq.size() < 2);
                if (mq.size() > 0 && sr_q) begin
                    if (m_idx == NB - 1) begin
                        void'(mq.pop_front());
                        m_idx = 0;
                        m_cnt = m_cnt + 1'b1;
                    end else begin
                        m_idx++;
                    end
                end
                if (acc) mq.push_back(pd_q);
                if (cap_sv && sr_q) begin
                    xfer_cyc.push_back(cyc);
                    if (c_idx < WIDTH) c_cur[c_idx] = cap_sd;
                    c_idx++;
                    if (cap_sl) begin
                        words_out.push_back(c_cur);
                        lens_out.push_back(c_idx);
                        last_bit.push_back(cap_sd);
                        c_idx = 0;
                        c_cur = '0;
                    end
                end
            end
            if (!parallel_ready) saw_nr = 1'b1;
            chk("cyc_valid", serial_valid, mq.size() > 0);
            chk("cyc_data", serial_data, (mq.size() > 0) ? exp_bit(mq[0], m_idx) : 1'b0);
            chk("cyc_last", serial_last, (mq.size() > 0) && (m_idx == NB - 1));
            chk("cyc_pready", parallel_ready, mq.size() < 2);
            chk("cyc_wcnt", word_cnt, m_cnt);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        words_out.delete();
        lens_out.delete();
        last_bit.delete();
        xfer_cyc.delete();
        saw_nr = 1'b0;
    endtask

    // Offers w and returns after the edge that accepts it; pv stays high
    task automatic send(input logic [WIDTH-1:0] w);
        int n = 0;
        pd = w;
        pv = 1'b1;
        while (!parallel_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) timeout("send");
        tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        tick();
        tick();
        while (mq.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) timeout("wait_idle");
    endtask

    task automatic wait_xfers(input int k);
        int n = 0;
        while (xfer_cyc.size() < k && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) timeout("wait_xfers");
    endtask

    initial begin
        int sent;
        int guard;
        logic rdy_seen;

        repeat (3) tick();
        chk("rst_pready", parallel_ready, 1'b1);
        chk("rst_valid", serial_valid, 1'b0);
        chk("rst_data", serial_data, 1'b0);
        chk("rst_last", serial_last, 1'b0);
        chk("rst_wcnt", word_cnt, 16'd0);
        rst = 1'b1;

        // Basic serialization
        sr = 1'b1;
        clear_obs();
        send(8'hA5);
        pv = 1'b0;
        wait_idle();
        chk("t1_words", words_out.size(), 1);
        chk("t1_data", words_out[0], 8'hA5);
        chk("t1_len", lens_out[0], NB);
        chk("t1_contig", xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[0], NB - 1);
        chk("t1_wcnt", word_cnt, 16'd1);
        chk("t1_model_cnt", m_cnt, 16'd1);

        // Back-to-back words
        clear_obs();
        send(8'h01);
        send(8'h80);
        send(8'hFF);
        pv = 1'b0;
        wait_idle();
        chk("t2_words", words_out.size(), 3);
        chk("t2_w0", words_out[0], 8'h01);
        chk("t2_w1", words_out[1], 8'h80);
        chk("t2_w2", words_out[2], 8'hFF);
        chk("t2_beats", xfer_cyc.size(), 3 * NB);
        chk("t2_nobubble", xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[0], 3 * NB - 1);
        chk("t2_ready_drop", saw_nr, 1'b1);
        chk("t2_wcnt", word_cnt, 16'd4);

        // Backpressure at beat 3, second word parked in B
        clear_obs();
        send(8'h3C);
        pv = 1'b0;
        wait_xfers(2);
        sr = 1'b0;
        send(8'h5A);
        pv = 1'b0;
        chk("t3_bfull", parallel_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_valid", serial_valid, 1'b1);
            chk("t3_hold_data", serial_data, 1'b1);
            chk("t3_hold_last", serial_last, 1'b0);
            tick();
        end
        chk("t3_stalled", xfer_cyc.size(), 2);
        sr = 1'b1;
        wait_idle();
        chk("t3_words", words_out.size(), 2);
        chk("t3_w0", words_out[0], 8'h3C);
        chk("t3_w1", words_out[1], 8'h5A);
        chk("t3_wcnt", word_cnt, 16'd6);

        // Reset in the middle of a word
        clear_obs();
        send(8'hF0);
        pv = 1'b0;
        wait_xfers(3);
        #2;
        rst = 1'b0;
        #1;
        chk("t4_valid", serial_valid, 1'b0);
        chk("t4_data", serial_data, 1'b0);
        chk("t4_last", serial_last, 1'b0);
        chk("t4_pready", parallel_ready, 1'b1);
        chk("t4_wcnt", word_cnt, 16'd0);
        tick();
        tick();
        rst = 1'b1;
        clear_obs();
        repeat (12) tick();
        chk("t4_no_beats", xfer_cyc.size(), 0);
        chk("t4_wcnt_after", word_cnt, 16'd0);

`ifdef PARALLEL_TO_SERIAL_PARITY_EN
        // Parity framing
        clear_obs();
        send(8'h07);
        pv = 1'b0;
        wait_idle();
        chk("t5_len", lens_out[0], 9);
        chk("t5_data", words_out[0], 8'h07);
        chk("t5_parity", last_bit[0], 1'b1);
        chk("t5_wcnt", word_cnt, 16'd1);
`endif

        // Random soak
        clear_obs();
        sent = 0;
        guard = 0;
        rdy_seen = 1'b0;
        while (sent < 100 && guard < 20000) begin
            tick();
            guard++;
            if (pv && rdy_seen) sent++;
            rdy_seen = parallel_ready;
            pv = (sent < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
            pd = WIDTH'($urandom);
            sr = 1'($urandom_range(0, 1));
        end
        if (guard >= 20000) timeout("soak");
        pv = 1'b0;
        sr = 1'b1;
        wait_idle();
        chk("t6_words", words_out.size(), 100);
        chk("t6_wcnt", word_cnt, 16'(BASE + 100));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parallel_to_serial.md
PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

Interface
REQ-001 Parameter WIDTH, default 8, is the parallel word width in bits, minimum 2.
REQ-002 Parameter CNT_W, default 16, is the width of the sent-word counter.
REQ-003 Port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port parallel_valid, input, 1 bit: parallel_data is offered.
REQ-006 Port parallel_data, input, WIDTH bits: word to serialize.
REQ-007 Port parallel_ready, output, 1 bit: a word is accepted at a rising edge when parallel_valid and parallel_ready are both high.
REQ-008 Port serial_valid, output, 1 bit: serial_data holds a valid beat.
REQ-009 Port serial_data, output, 1 bit: current beat.
REQ-010 Port serial_last, output, 1 bit: current beat is the final beat of its word.
REQ-011 Port serial_ready, input, 1 bit: a beat transfers at a rising edge when serial_valid and serial_ready are both high.
REQ-012 Port word_cnt, output, CNT_W bits: number of words fully transmitted.

Function
REQ-013 Storage SHALL be one shift register S plus one holding buffer B, giving capacity for 2 words, with acceptance order preserved.
REQ-014 FSM states:
- IDLE: S is empty.
- SHIFT: S is loaded.
REQ-015 IDLE SHALL go to SHIFT on a load of S; SHIFT SHALL go to IDLE on the last-beat transfer when B is empty and no word is accepted that edge.
REQ-016 parallel_ready SHALL be registered and equal to "B empty" after every edge.
REQ-017 Routing of an accepted word:
- S is empty, or S is transferring its last beat while B is empty: the word loads S.
- Otherwise: the word loads B.
REQ-018 On a last-beat transfer with B full, S SHALL load from B at the same edge, with no bubble, and B becomes empty.
REQ-019 Bits SHALL be sent LSB first: beat k carries parallel_data[k], k = 0..WIDTH-1.
REQ-020 serial_valid SHALL be high in the cycle after the edge that loads S from IDLE; the accept-to-first-beat latency is 1 cycle.
REQ-021 A bit counter SHALL advance only on a beat transfer and wrap to 0 after the last beat.
REQ-022 serial_data, serial_valid and serial_last SHALL hold stable while serial_valid is high and serial_ready is low.
REQ-023 serial_last SHALL be high only on the final beat of each word.
REQ-024 word_cnt SHALL increment by 1 on each last-beat transfer and wrap modulo 2^CNT_W.
REQ-025 When serial_ready is held high and a word is offered every WIDTH cycles, serial_valid SHALL stay continuously high once started.
REQ-026 serial_data SHALL be 0 whenever serial_valid is low.

Reset
REQ-027 rst low SHALL immediately force all of the following:
- parallel_ready = 1;
- serial_valid = 0, serial_data = 0, serial_last = 0;
- word_cnt = 0;
- S and B empty, bit counter = 0, FSM = IDLE.
REQ-028 Reset asserted mid-word SHALL discard the partial word and any buffered word; no beats follow deassertion until a new accept.
REQ-029 The first accept SHALL be possible at the first rising edge after rst goes high.

Configuration
REQ-030 Macro PARALLEL_TO_SERIAL_PARITY_EN SHALL select the word framing:
- Defined: each word is sent as WIDTH+1 beats; the extra final beat is even parity (XOR of the WIDTH data bits), and serial_last marks that parity beat.
- Undefined: each word is sent as WIDTH beats with no parity logic.

Verification
REQ-031 Basic serialization: after reset, accept 8'hA5 with serial_ready held 1 -> beats 1,0,1,0,0,1,0,1 on 8 consecutive cycles; serial_last on beat 8; word_cnt = 1.
REQ-032 Back-to-back words: offer 8'h01, 8'h80, 8'hFF continuously with serial_ready = 1 -> 24 contiguous valid beats with no bubble; parallel_ready drops while B is full; word_cnt = 3.
REQ-033 Backpressure: serial_ready = 0 for 5 cycles at beat 3 of 8'h3C -> the beat holds stable; the sequence resumes unchanged; a second accepted word waits in B.
REQ-034 Mid-word reset: rst asserted low at beat 4 of 8'hF0 -> outputs reach their reset values immediately; no stray beats after release; word_cnt = 0.
REQ-035 Parity (PARALLEL_TO_SERIAL_PARITY_EN defined): send 8'h07 -> 9 beats, parity beat = 1, serial_last on beat 9.
REQ-036 Random soak: 100 random words with random valid and ready -> the scoreboard matches the serial stream LSB-first and word_cnt = 100.
